// File: rtl/mem_store_ctrl_pkg.sv
// Shared definitions for the byte-serial store path.
// Contents: store width encodings, default IO select value, FSM state enum,
// packed store-request payload, and a width-to-last-byte-index helper.
package mem_store_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ST_B = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_W = 2'b10;

  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        width;
  } st_req_t;

  // Index of the final byte of a store; the reserved width behaves as a byte.
  function automatic logic [1:0] last_idx(input logic [1:0] width);
    logic [1:0] r;
    case (width)
      ST_B:    r = 2'd0;
      ST_H:    r = 2'd1;
      ST_W:    r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Store-request FIFO placed in front of the serialising FSM when the store
// queue is enabled (MEM_STORE_QUEUE_EN in the top).
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the queue)
//   push, din : enqueue din (caller never pushes when full)
//   pop       : dequeue head (caller never pops when empty)
//   full      : QDEPTH entries held
//   empty     : no entries held
//   head      : oldest entry, valid when !empty
// QDEPTH must be a power of two, at least 2.
module store_fifo
  import mem_store_ctrl_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  st_req_t din,
  output logic    full,
  output logic    empty,
  output st_req_t head
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;

  st_req_t       slots [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= din;
  end

  assign full  = (count == CW'(QDEPTH));
  assign empty = (count == '0);
  assign head  = slots[rd_ptr];

endmodule

// File: rtl/mem_store_ctrl.sv
// Byte-serial store path to the unified byte-wide RAM/IO port. Each accepted
// byte/half/word store is issued as consecutive single-byte writes, LSB first;
// bytes to IO-mapped addresses stall while the IO buffer is full. st_done
// pulses one cycle after a store's final byte is issued.
// Optional feature macro: MEM_STORE_QUEUE_EN adds a QDEPTH-entry request FIFO
// so requests can be accepted while a store is in progress.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   rdy                      : global enable; low freezes all state
//   st_valid/st_ready        : request handshake
//   st_addr/st_data/st_width : request payload (width 00 B, 01 H, 10 W, 11 as B)
//   st_done                  : one-cycle completion pulse
//   mem_a/mem_write/mem_wr   : RAM byte address, data, write strobe
//   io_buffer_full           : IO buffer cannot take a write
module mem_store_ctrl
  import mem_store_ctrl_pkg::*;
#(
  parameter logic [1:0]  IO_SEL = IO_SEL_DEFAULT,
  parameter int unsigned QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_width,
  output logic        st_done,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_write,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t     state;
  state_t     state_next;
  logic [1:0] idx;
  logic [1:0] idx_next;
  st_req_t    in_req;
  st_req_t    cur_req;
  st_req_t    src_req;
  logic       accept;
  logic       stall;
  logic       issue;
  logic       last;
  logic       load_next;
  logic       load_en;
  logic       src_avail;
  logic       done_pend;

  assign in_req = '{addr: st_addr, data: st_data, width: st_width};
  assign accept = st_valid && st_ready && rdy;
  assign stall  = (cur_req.addr[17:16] == IO_SEL) && io_buffer_full;

`ifdef MEM_STORE_QUEUE_EN
  logic    q_push;
  logic    q_pop;
  logic    q_full;
  logic    q_empty;
  st_req_t q_head;

  store_fifo #(.QDEPTH(QDEPTH)) u_store_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .din   (in_req),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  // Queued entries take priority; an incoming request bypasses an empty queue.
  assign st_ready  = !q_full;
  assign src_avail = !q_empty || accept;
  assign src_req   = q_empty ? in_req : q_head;
  assign q_pop     = load_en && !q_empty;
  assign q_push    = accept && !(load_en && q_empty);
`else
  logic unused_cfg;

  assign st_ready   = (state == IDLE);
  assign src_avail  = accept;
  assign src_req    = in_req;
  assign unused_cfg = ^32'(QDEPTH);
`endif

  // State and byte-index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next state: a new store can be loaded in IDLE or right as the last byte
  // issues, which keeps back-to-back stores free of bubbles.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    issue      = 1'b0;
    last       = 1'b0;
    load_next  = 1'b0;
    if (rdy) begin
      case (state)
        IDLE: load_next = 1'b1;
        WRITE: begin
          if (!stall) begin
            issue    = 1'b1;
            idx_next = idx + 2'd1;
            if (idx == last_idx(cur_req.width)) begin
              last       = 1'b1;
              load_next  = 1'b1;
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
      if (load_next && src_avail) begin
        state_next = WRITE;
        idx_next   = 2'd0;
      end
    end
  end

  assign load_en = load_next && src_avail;

  // Registered RAM port, completion pulse and working request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_req   <= '0;
      mem_a     <= 32'd0;
      mem_write <= 8'd0;
      mem_wr    <= 1'b0;
      st_done   <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      mem_wr <= issue;
      if (issue) begin
        mem_a     <= cur_req.addr + 32'(idx);
        mem_write <= cur_req.data[{idx, 3'b000} +: 8];
      end
      // A pending completion waits out any rdy-low cycles rather than stretching.
      if (rdy) begin
        st_done   <= done_pend;
        done_pend <= last;
      end else begin
        st_done <= 1'b0;
      end
      if (load_en) cur_req <= src_req;
    end
  end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Self-checking bench for mem_store_ctrl: a transaction-level model (pending
// request list, current store, byte counter) predicts every output each
// cycle; directed tests also pin write logs against literal expectations.
module tb_mem_store_ctrl;

`ifdef MEM_STORE_QUEUE_EN
  localparam bit QMODE = 1'b1;
`else
  localparam bit QMODE = 1'b0;
`endif
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, st_valid, io_full;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_width;
  logic        st_ready, st_done, mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_write;

  mem_store_ctrl #(.IO_SEL(2'b11), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_width(st_width), .st_done(st_done),
    .mem_a(mem_a), .mem_write(mem_write), .mem_wr(mem_wr),
    .io_buffer_full(io_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; int n; bit io; } req_t;
  typedef struct { int c; logic [31:0] a; logic [7:0] d; } wr_t;

  req_t pend[$];
  req_t cur, m_r;
  bit   busy, done_due, m_free, armed, m_accepted;
  int   k, cyc, acc_cyc;
  bit   e_ready, e_done, e_wr;
  logic [31:0] e_a;
  logic [7:0]  e_d;
  wr_t  wlog[$];
  int   dlog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_wr(input string nm, input int i, input int c,
                          input logic [31:0] a, input logic [7:0] d);
    checks++;
    if (i >= wlog.size()) begin
      errors++;
      $display("FAIL %s: write %0d missing, only %0d logged", nm, i, wlog.size());
    end else if (wlog[i].c != c || wlog[i].a !== a || wlog[i].d !== d) begin
      errors++;
      $display("FAIL %s: write %0d got cyc %0d a %h d %h expected cyc %0d a %h d %h",
               nm, i, wlog[i].c, wlog[i].a, wlog[i].d, c, a, d);
    end
  endtask

  // Transaction model: every accepted request joins a pending list; a free
  // engine takes the oldest one; each unstalled cycle emits one byte.
  always @(posedge clk) begin
    cyc++;
    m_accepted = 1'b0;
    if (rst) begin
      armed = 1'b1; busy = 1'b0; k = 0; done_due = 1'b0; pend.delete();
      e_wr = 1'b0; e_done = 1'b0; e_a = 32'd0; e_d = 8'd0; e_ready = 1'b1;
    end else if (armed) begin
      if (!rdy) begin
        e_wr = 1'b0; e_done = 1'b0;
      end else begin
        e_done = done_due; done_due = 1'b0; e_wr = 1'b0;
        if (st_valid && e_ready) begin
          m_r.a  = st_addr;
          m_r.d  = st_data;
          m_r.n  = (st_width == 2'b01) ? 2 : (st_width == 2'b10) ? 4 : 1;
          m_r.io = (st_addr[17:16] == 2'b11);
          pend.push_back(m_r);
          m_accepted = 1'b1;
          acc_cyc = cyc;
        end
        m_free = !busy;
        if (busy && !(cur.io && io_full)) begin
          e_wr = 1'b1;
          e_a  = cur.a + 32'(k);
          e_d  = 8'(cur.d >> (8 * k));
          k++;
          if (k == cur.n) begin done_due = 1'b1; busy = 1'b0; m_free = 1'b1; end
        end
        if (m_free && pend.size() > 0) begin
          cur = pend.pop_front(); busy = 1'b1; k = 0;
        end
        e_ready = QMODE ? (pend.size() < QD) : !busy;
      end
    end
  end

  // Compare every output each cycle, and log writes/completions.
  always @(negedge clk) begin
    if (armed) begin
      chk("st_ready", 32'(st_ready), 32'(e_ready));
      chk("st_done", 32'(st_done), 32'(e_done));
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("mem_a", mem_a, e_a);
      chk("mem_write", 32'(mem_write), 32'(e_d));
      if (mem_wr === 1'b1) wlog.push_back('{cyc, mem_a, mem_write});
      if (st_done === 1'b1) dlog.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] w, output int t);
    int n;
    n = 0;
    st_valid = 1'b1; st_addr = a; st_data = d; st_width = w;
    do begin @(posedge clk); #2; n++; end while (!m_accepted && n < 40);
    checks++;
    if (!m_accepted) begin
      errors++;
      $display("FAIL accept_timeout: addr %h not accepted after %0d cycles", a, n);
    end
    t = acc_cyc;
    st_valid = 1'b0;
  endtask

  task automatic clear_logs();
    wlog.delete();
    dlog.delete();
  endtask

  initial begin
    int t, t2;
    cyc = 0; armed = 1'b0;
    rst = 1'b1; rdy = 1'b1; st_valid = 1'b0; io_full = 1'b0;
    st_addr = 32'd0; st_data = 32'd0; st_width = 2'b00;
    tick(2);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_st_done", 32'(st_done), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("ready_after_rst", 32'(st_ready), 32'd1);

    // Word store.
    clear_logs();
    send(32'h100, 32'hDDCCBBAA, 2'b10, t);
    tick(7);
    check_wr("word", 0, t + 1, 32'h100, 8'hAA);
    check_wr("word", 1, t + 2, 32'h101, 8'hBB);
    check_wr("word", 2, t + 3, 32'h102, 8'hCC);
    check_wr("word", 3, t + 4, 32'h103, 8'hDD);
    chk_int("word_nwr", wlog.size(), 4);
    chk_int("word_ndone", dlog.size(), 1);
    if (dlog.size() > 0) chk_int("word_done_cyc", dlog[0], t + 5);

    // Half store wrapping past the top of the address space.
    clear_logs();
    send(32'hFFFF_FFFF, 32'h0000_1234, 2'b01, t);
    tick(5);
    check_wr("half_wrap", 0, t + 1, 32'hFFFF_FFFF, 8'h34);
    check_wr("half_wrap", 1, t + 2, 32'h0000_0000, 8'h12);
    chk_int("half_nwr", wlog.size(), 2);
    if (dlog.size() > 0) chk_int("half_done_cyc", dlog[0], t + 3);
    else chk_int("half_ndone", 0, 1);

    // IO byte store stalled three cycles.
    clear_logs();
    send(32'h0003_0000, 32'h0000_0077, 2'b00, t);
    io_full = 1'b1;
    tick(3);
    io_full = 1'b0;
    tick(4);
    check_wr("io_stall", 0, t + 4, 32'h0003_0000, 8'h77);
    chk_int("io_nwr", wlog.size(), 1);
    if (dlog.size() > 0) chk_int("io_done_cyc", dlog[0], t + 5);
    else chk_int("io_ndone", 0, 1);

    // Non-IO address ignores io_buffer_full; reserved width acts as byte.
    clear_logs();
    io_full = 1'b1;
    send(32'h0002_0005, 32'hA5A5_A5C3, 2'b11, t);
    tick(4);
    io_full = 1'b0;
    check_wr("nonio_rsvd", 0, t + 1, 32'h0002_0005, 8'hC3);
    chk_int("nonio_nwr", wlog.size(), 1);
    chk_int("nonio_ndone", dlog.size(), 1);

    // rdy dropped for two cycles after the first byte.
    clear_logs();
    send(32'h200, 32'h4433_2211, 2'b10, t);
    tick(1);
    rdy = 1'b0;
    tick(2);
    rdy = 1'b1;
    tick(6);
    check_wr("rdy_drop", 0, t + 1, 32'h200, 8'h11);
    check_wr("rdy_drop", 1, t + 4, 32'h201, 8'h22);
    check_wr("rdy_drop", 2, t + 5, 32'h202, 8'h33);
    check_wr("rdy_drop", 3, t + 6, 32'h203, 8'h44);
    chk_int("rdy_nwr", wlog.size(), 4);
    if (dlog.size() > 0) chk_int("rdy_done_cyc", dlog[0], t + 7);
    else chk_int("rdy_ndone", 0, 1);

    // Reset after byte 2 of a word store, then a fresh byte store.
    clear_logs();
    send(32'h300, 32'h8877_6655, 2'b10, t);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);
    check_wr("rst_mid", 0, t + 1, 32'h300, 8'h55);
    check_wr("rst_mid", 1, t + 2, 32'h301, 8'h66);
    chk_int("rst_mid_nwr", wlog.size(), 2);
    chk_int("rst_mid_ndone", dlog.size(), 0);
    clear_logs();
    send(32'h400, 32'h0000_005A, 2'b00, t);
    tick(3);
    check_wr("after_rst", 0, t + 1, 32'h400, 8'h5A);
    if (dlog.size() > 0) chk_int("after_rst_done_cyc", dlog[0], t + 2);
    else chk_int("after_rst_ndone", 0, 1);

    // Back-to-back requests.
    clear_logs();
    send(32'h500, 32'h0000_BBAA, 2'b01, t);
    send(32'h600, 32'h0000_00CC, 2'b00, t2);
    tick(5);
`ifndef MEM_STORE_QUEUE_EN
    chk_int("b2b_accept_cyc", t2, t + 3);
    check_wr("b2b", 2, t + 4, 32'h600, 8'hCC);
`endif
    chk_int("b2b_nwr", wlog.size(), 3);
    chk_int("b2b_ndone", dlog.size(), 2);

`ifdef MEM_STORE_QUEUE_EN
    // Five IO byte stores while the IO buffer is full fill the queue.
    clear_logs();
    io_full = 1'b1;
    for (int i = 0; i < 5; i++) send(32'h0003_0000 + 32'(i), 32'(8'hE0 + i), 2'b00, t);
    chk("q_full_ready", 32'(st_ready), 32'd0);
    tick(2);
    chk("q_full_ready_hold", 32'(st_ready), 32'd0);
    t2 = cyc;
    io_full = 1'b0;
    tick(8);
    for (int i = 0; i < 5; i++)
      check_wr("queue", i, t2 + 1 + i, 32'h0003_0000 + 32'(i), 8'(8'hE0 + i));
    chk_int("queue_ndone", dlog.size(), 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
